// File: rtl/eval_pkg.sv
// Shared definitions for the evaluation harness controller.
//   eval_state_t : controller phases IDLE -> LOAD -> RELEASE -> RUN -> DONE
//   IMG_BYTE_W   : width of one program image byte
//   ptr_w()      : pointer width for a FIFO of the given depth (at least 1 bit)
package eval_pkg;

  localparam int IMG_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RELEASE,
    RUN,
    DONE
  } eval_state_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/eval_out_fifo.sv
// First-word-fall-through capture FIFO for cpu output words.
// Ports:
//   clk, reset    clock, synchronous active-low reset
//   flush         empties the FIFO and clears the overflow flag
//   push/push_data  write request and word
//   pop           read request (honoured only when a word is present)
//   out_valid     head word present
//   out_data      head word, zero when empty
//   overflow      sticky: a push was dropped because the FIFO was full
module eval_out_fifo
  import eval_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              overflow
);

  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_V = (PW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic              empty;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_V);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (push && !do_push) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/eval_harness_ctrl.sv
// Program-load-and-run controller wrapping one Tinker cpu.
// Streams a byte image into cpu memory with the cpu held in reset, releases it,
// runs until halt or a cycle budget expires, and captures every cpu output
// pulse into a FIFO.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   start                      begin a load (accepted only in IDLE or DONE)
//   img_valid/ready/addr/data/last   image byte stream
//   mem_we/addr/wdata          cpu memory byte write, one cycle after acceptance
//   cpu_reset                  active-high cpu reset, low only in RUN
//   cpu_halt/out_sig/out_data  cpu status and output pulses
//   out_valid/ready/data       capture FIFO head
//   busy, done, timed_out, overflow, run_cycles   status
// Optional build macro EVAL_LOAD_CHECKSUM_EN adds load_sum: wrapping 32-bit sum
// of the accepted image bytes since the last start.
module eval_harness_ctrl
  import eval_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 40,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  img_valid,
  output logic                  img_ready,
  input  logic [ADDR_W-1:0]     img_addr,
  input  logic [IMG_BYTE_W-1:0] img_data,
  input  logic                  img_last,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [IMG_BYTE_W-1:0] mem_wdata,
  output logic                  cpu_reset,
  input  logic                  cpu_halt,
  input  logic                  cpu_out_sig,
  input  logic [DATA_W-1:0]     cpu_out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  busy,
  output logic                  done,
  output logic                  timed_out,
  output logic                  overflow,
`ifdef EVAL_LOAD_CHECKSUM_EN
  output logic [31:0]           load_sum,
`endif
  output logic [CNT_W-1:0]      run_cycles
);

  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT_CYC - 1);

  eval_state_t state;
  eval_state_t state_next;
  logic        accept;
  logic        start_ok;
  logic        run_end;

  assign img_ready = (state == LOAD);
  assign accept    = img_ready && img_valid;
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign run_end   = cpu_halt || (run_cycles == RUN_LAST);
  assign cpu_reset = (state != RUN);
  assign busy      = (state == LOAD) || (state == RELEASE) || (state == RUN);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = LOAD;
      LOAD:    if (accept && img_last) state_next = RELEASE;
      RELEASE: state_next = RUN;
      RUN:     if (run_end) state_next = DONE;
      DONE:    if (start_ok) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // Each accepted byte becomes a single-cycle memory write on the next cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= accept;
      if (accept) begin
        mem_addr  <= img_addr;
        mem_wdata <= img_data;
      end
    end
  end

  // The counter stops on the cycle the run ends, so it reports the cycle index
  // at which halt or the budget was seen. Halt takes priority over timeout.
  always_ff @(posedge clk) begin
    if (!reset) begin
      run_cycles <= '0;
      timed_out  <= 1'b0;
    end else if (start_ok) begin
      run_cycles <= '0;
      timed_out  <= 1'b0;
    end else if (state == RUN) begin
      if (cpu_halt) begin
        timed_out <= 1'b0;
      end else if (run_cycles == RUN_LAST) begin
        timed_out <= 1'b1;
      end else begin
        run_cycles <= run_cycles + CNT_W'(1);
      end
    end
  end

`ifdef EVAL_LOAD_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset || start_ok) begin
      load_sum <= '0;
    end else if (accept) begin
      load_sum <= load_sum + {24'b0, img_data};
    end
  end
`endif

  // Captures include the final RUN cycle, where halt or timeout is seen.
  eval_out_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (start_ok),
    .push     ((state == RUN) && cpu_out_sig),
    .push_data(cpu_out_data),
    .pop      (out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_eval_harness_ctrl.sv
// Self-checking bench for eval_harness_ctrl (FIFO_DEPTH=4, TIMEOUT_CYC=40).
// Build with EVAL_LOAD_CHECKSUM_EN to also check load_sum.
module tb_eval_harness_ctrl;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 40;

  logic        clk;
  logic        reset;
  logic        start;
  logic        img_valid;
  logic        img_ready;
  logic [31:0] img_addr;
  logic [7:0]  img_data;
  logic        img_last;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_reset;
  logic        cpu_halt;
  logic        cpu_out_sig;
  logic [63:0] cpu_out_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;
  logic        done;
  logic        timed_out;
  logic        overflow;
  logic [31:0] run_cycles;
`ifdef EVAL_LOAD_CHECKSUM_EN
  logic [31:0] load_sum;
`endif

  eval_harness_ctrl #(
    .ADDR_W     (32),
    .DATA_W     (64),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT_CYC(TIMEOUT),
    .CNT_W      (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .img_valid   (img_valid),
    .img_ready   (img_ready),
    .img_addr    (img_addr),
    .img_data    (img_data),
    .img_last    (img_last),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_reset   (cpu_reset),
    .cpu_halt    (cpu_halt),
    .cpu_out_sig (cpu_out_sig),
    .cpu_out_data(cpu_out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done),
    .timed_out   (timed_out),
    .overflow    (overflow),
`ifdef EVAL_LOAD_CHECKSUM_EN
    .load_sum    (load_sum),
`endif
    .run_cycles  (run_cycles)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: expected memory writes, captured words, sticky overflow, byte sum.
  logic [39:0] exp_wr[$];
  logic [39:0] obs_wr[$];
  logic [63:0] model_q[$];
  bit          exp_ovf;
  logic [31:0] exp_sum;

  // Per-run-cycle stimulus tables.
  logic        sig_tab[64];
  logic [63:0] dat_tab[64];
  logic        rdy_tab[64];
  logic        start_tab[64];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) obs_wr.push_back({mem_addr, mem_wdata});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_tabs();
    for (int i = 0; i < 64; i++) begin
      sig_tab[i]   = 1'b0;
      dat_tab[i]   = {$urandom, $urandom};
      rdy_tab[i]   = 1'b0;
      start_tab[i] = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (cpu_reset !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        timed_out !== 1'b0 || overflow !== 1'b0 || img_ready !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got cr=%b ov=%b busy=%b done=%b to=%b ovf=%b rdy=%b we=%b expected 1 0 0 0 0 0 0 0",
               cpu_reset, out_valid, busy, done, timed_out, overflow, img_ready, mem_we);
    end
    checks++;
    if (run_cycles !== 32'd0 || out_data !== 64'd0 || mem_addr !== 32'd0 || mem_wdata !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_values: got rc=%0d od=%0h ma=%0h md=%0h expected all 0",
               run_cycles, out_data, mem_addr, mem_wdata);
    end
`ifdef EVAL_LOAD_CHECKSUM_EN
    checks++;
    if (load_sum !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_sum: got %0h expected 0", load_sum);
    end
`endif
    reset = 1'b1;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_q.delete();
    exp_ovf = 1'b0;
    exp_sum = 32'd0;
    checks++;
    if (busy !== 1'b1 || img_ready !== 1'b1 || done !== 1'b0 || timed_out !== 1'b0 ||
        overflow !== 1'b0 || run_cycles !== 32'd0 || out_valid !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_clears: got busy=%b rdy=%b done=%b to=%b ovf=%b rc=%0d ov=%b cr=%b expected 1 1 0 0 0 0 0 1",
               busy, img_ready, done, timed_out, overflow, run_cycles, out_valid, cpu_reset);
    end
`ifdef EVAL_LOAD_CHECKSUM_EN
    checks++;
    if (load_sum !== 32'd0) begin
      errors++;
      $display("[TB] FAIL start_sum: got %0h expected 0", load_sum);
    end
`endif
  endtask

  // Streams n bytes (fixed pattern 0x11*(i+1) at address i, or random), then
  // checks the release sequence and the memory writes that came out.
  task automatic load_image(input int n, input bit fixed, input bit bubbles);
    logic [7:0]  d;
    logic [31:0] a;
    exp_wr.delete();
    obs_wr.delete();
    for (int i = 0; i < n; i++) begin
      if (bubbles) begin
        img_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      d = fixed ? 8'((i + 1) * 8'h11) : 8'($urandom);
      a = fixed ? 32'(i) : $urandom;
      img_valid = 1'b1;
      img_data  = d;
      img_addr  = a;
      img_last  = (i == n - 1);
      exp_wr.push_back({a, d});
      exp_sum = exp_sum + 32'(d);
      tick();
    end
    img_valid = 1'b0;
    img_last  = 1'b0;
    checks++;
    if (cpu_reset !== 1'b1 || busy !== 1'b1 || img_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release_cycle: got cr=%b busy=%b rdy=%b expected 1 1 0", cpu_reset, busy, img_ready);
    end
    tick();
    checks++;
    if (cpu_reset !== 1'b0 || run_cycles !== 32'd0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL run_entry: got cr=%b rc=%0d busy=%b expected 0 0 1", cpu_reset, run_cycles, busy);
    end
    checks++;
    if (obs_wr.size() != exp_wr.size()) begin
      errors++;
      $display("[TB] FAIL write_count: got %0d expected %0d", obs_wr.size(), exp_wr.size());
    end else begin
      for (int i = 0; i < exp_wr.size(); i++) begin
        checks++;
        if (obs_wr[i] !== exp_wr[i]) begin
          errors++;
          $display("[TB] FAIL write_%0d: got addr/data %0h expected %0h", i, obs_wr[i], exp_wr[i]);
        end
      end
    end
`ifdef EVAL_LOAD_CHECKSUM_EN
    checks++;
    if (load_sum !== exp_sum) begin
      errors++;
      $display("[TB] FAIL load_sum: got %0h expected %0h", load_sum, exp_sum);
    end
`endif
  endtask

  // Runs the cpu phase from the tables; halt_at < 0 means never halt.
  task automatic run_phase(input int halt_at);
    int  k;
    bit  fin;
    bit  exp_to;
    obs_wr.delete();
    img_valid = 1'b1;
    k = 0;
    fin = 1'b0;
    exp_to = 1'b0;
    while (!fin) begin
      checks++;
      if (run_cycles !== 32'(k) || done !== 1'b0 || cpu_reset !== 1'b0) begin
        errors++;
        $display("[TB] FAIL run_progress: got rc=%0d done=%b cr=%b expected %0d 0 0", run_cycles, done, cpu_reset, k);
      end
      cpu_out_sig  = sig_tab[k];
      cpu_out_data = dat_tab[k];
      cpu_halt     = (k == halt_at);
      out_ready    = rdy_tab[k];
      start        = start_tab[k];
      img_data     = 8'($urandom);
      img_addr     = $urandom;
      if (rdy_tab[k] && model_q.size() > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== model_q[0]) begin
          errors++;
          $display("[TB] FAIL run_pop: got v=%b d=%0h expected 1 %0h", out_valid, out_data, model_q[0]);
        end
        void'(model_q.pop_front());
      end
      if (sig_tab[k]) begin
        if (model_q.size() < DEPTH) model_q.push_back(dat_tab[k]);
        else exp_ovf = 1'b1;
      end
      fin    = (k == halt_at) || (k == TIMEOUT - 1);
      exp_to = (k != halt_at) && (k == TIMEOUT - 1);
      tick();
      k++;
    end
    cpu_out_sig = 1'b0;
    cpu_halt    = 1'b0;
    out_ready   = 1'b0;
    start       = 1'b0;
    img_valid   = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cpu_reset !== 1'b1 || timed_out !== exp_to) begin
      errors++;
      $display("[TB] FAIL run_end: got done=%b busy=%b cr=%b to=%b expected 1 0 1 %b", done, busy, cpu_reset, timed_out, exp_to);
    end
    checks++;
    if (run_cycles !== 32'(k - 1) || overflow !== exp_ovf || out_valid !== (model_q.size() > 0)) begin
      errors++;
      $display("[TB] FAIL run_result: got rc=%0d ovf=%b ov=%b expected %0d %b %b",
               run_cycles, overflow, out_valid, k - 1, exp_ovf, model_q.size() > 0);
    end
    tick();
    checks++;
    if (run_cycles !== 32'(k - 1) || done !== 1'b1 || obs_wr.size() != 0) begin
      errors++;
      $display("[TB] FAIL done_hold: got rc=%0d done=%b writes=%0d expected %0d 1 0", run_cycles, done, obs_wr.size(), k - 1);
    end
  endtask

  task automatic drain_check();
    int n;
    n = model_q.size();
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== model_q[i]) begin
        errors++;
        $display("[TB] FAIL drain_%0d: got v=%b d=%0h expected 1 %0h", i, out_valid, out_data, model_q[i]);
      end
      tick();
    end
    model_q.delete();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'd0 || overflow !== exp_ovf || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drain_empty: got v=%b d=%0h ovf=%b done=%b expected 0 0 %b 1", out_valid, out_data, overflow, done, exp_ovf);
    end
  endtask

  task automatic test_load_basic();
    do_start();
    load_image(4, 1'b1, 1'b0);
`ifdef EVAL_LOAD_CHECKSUM_EN
    checks++;
    if (load_sum !== 32'hAA) begin
      errors++;
      $display("[TB] FAIL sum_aa: got %0h expected aa", load_sum);
    end
`endif
  endtask

  task automatic test_run_halt();
    clear_tabs();
    sig_tab[2] = 1'b1; dat_tab[2] = 64'd5;
    sig_tab[6] = 1'b1; dat_tab[6] = 64'd7;
    start_tab[3] = 1'b1;
    run_phase(10);
    drain_check();
  endtask

  task automatic test_timeout();
    do_start();
    load_image(3, 1'b0, 1'b1);
    clear_tabs();
    sig_tab[1] = 1'b1;
    sig_tab[5] = 1'b1;
    sig_tab[39] = 1'b1;
    run_phase(-1);
    do_start();
    load_image(2, 1'b0, 1'b1);
    clear_tabs();
    sig_tab[39] = 1'b1;
    run_phase(39);
    drain_check();
  endtask

  task automatic test_fifo_overflow();
    do_start();
    load_image(1, 1'b0, 1'b0);
    clear_tabs();
    for (int i = 0; i < 5; i++) sig_tab[i] = 1'b1;
    rdy_tab[4] = 1'b1;
    run_phase(5);
    drain_check();
    do_start();
    load_image(1, 1'b0, 1'b0);
    clear_tabs();
    for (int i = 0; i < 6; i++) sig_tab[i] = 1'b1;
    rdy_tab[5] = 1'b1;
    run_phase(6);
    drain_check();
  endtask

  task automatic test_reset_mid_load();
    do_start();
    obs_wr.delete();
    for (int i = 0; i < 2; i++) begin
      img_valid = 1'b1;
      img_addr  = 32'(i);
      img_data  = 8'hE0 + 8'(i);
      img_last  = 1'b0;
      tick();
    end
    img_valid = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || img_ready !== 1'b0 || mem_we !== 1'b0 || cpu_reset !== 1'b1 ||
        done !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 8'd0) begin
      errors++;
      $display("[TB] FAIL mid_load_reset: got busy=%b rdy=%b we=%b cr=%b done=%b ma=%0h md=%0h expected 0 0 0 1 0 0 0",
               busy, img_ready, mem_we, cpu_reset, done, mem_addr, mem_wdata);
    end
    reset = 1'b1;
    tick();
    do_start();
    load_image(4, 1'b1, 1'b1);
    clear_tabs();
    run_phase(3);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      do_start();
      load_image($urandom_range(1, 6), 1'b0, 1'b1);
      clear_tabs();
      for (int i = 0; i < 64; i++) begin
        sig_tab[i] = 1'($urandom_range(0, 1));
        rdy_tab[i] = 1'($urandom_range(0, 1));
      end
      run_phase(int'($urandom_range(0, 45)));
      drain_check();
    end
  endtask

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    img_valid    = 1'b0;
    img_addr     = '0;
    img_data     = '0;
    img_last     = 1'b0;
    cpu_halt     = 1'b0;
    cpu_out_sig  = 1'b0;
    cpu_out_data = '0;
    out_ready    = 1'b0;
    exp_ovf      = 1'b0;
    exp_sum      = '0;
    test_reset();
    test_load_basic();
    test_run_halt();
    test_timeout();
    test_fifo_overflow();
    test_reset_mid_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
